uart_fifo_interface: RTL

- Second-generation 6809-side UART for the FT2232 serial link; replaces the single-byte, no-buffer UART interface.
- Adds:
  - 16x oversampled RX with mid-bit sampling and start-bit validation
  - parametrised RX and TX FIFOs
  - runtime-selectable parity and stop bits
  - sticky error flags, loopback, and a combined maskable interrupt
- Sits between the 6809 address decoder (one chip-select, 2-bit register address) and the FT2232 TX/RX pins.

---
 rtl/uart_fifo_interface.sv | 380 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_interface.sv
`default_nettype none
// uart_fifo_interface: 6809-side UART with 16x oversampled RX, RX/TX FIFOs,
// runtime parity/stop-bit selection, sticky errors, loopback and a maskable IRQ.

module uart_fifo_sync #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

module uart_fifo_interface #(
    parameter int CLK_DIV    = 577,
    parameter int FIFO_AW    = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cs,
    input  logic       i_rw,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_irq_n,
    input  logic       i_uart_rx,
    output logic       o_uart_tx
);
    localparam int         DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // ---------------- bus / register file ----------------
    logic       cs_q;
    logic       acc;
    logic       rd_acc;
    logic       wr_acc;
    logic [7:0] ctrl;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic [2:0] err_hold;
    logic [7:0] rx_hold;
    logic [7:0] rx_head;
    logic [7:0] status;
    logic [7:0] rd_mux;
    logic       err_clr;
    logic       irq_cond;

    logic       rx_ie;
    logic       tx_ie;
    logic       par_en;
    logic       par_odd;
    logic       two_stop;
    logic       loopback;

    // ---------------- tick / FIFOs ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic       txf_push;
    logic       txf_pop;
    logic [7:0] txf_dout;
    logic       txf_full;
    logic       txf_empty;
    logic       rxf_pop;
    logic       rxf_push;
    logic [7:0] rxf_dout;
    logic       rxf_full;
    logic       rxf_empty;

    // ---------------- TX ----------------
    tx_state_t  tx_state;
    tx_state_t  tx_state_n;
    logic [3:0] tx_scnt;
    logic [3:0] tx_scnt_n;
    logic [2:0] tx_bitn;
    logic [2:0] tx_bitn_n;
    logic [7:0] tx_shift;
    logic [7:0] tx_shift_n;
    logic       tx_par;
    logic       tx_par_n;
    logic       tx_line_n;
    logic       tx_done;
    logic       tx_bit_end;

    // ---------------- RX ----------------
    rx_state_t  rx_state;
    rx_state_t  rx_state_n;
    logic [3:0] rx_scnt;
    logic [3:0] rx_scnt_n;
    logic [2:0] rx_bitn;
    logic [2:0] rx_bitn_n;
    logic [7:0] rx_shift;
    logic [7:0] rx_shift_n;
    logic [1:0] rx_sync;
    logic       rx_line;
    logic       rx_bit_end;
    logic       rx_push_req;
    logic       rx_perr_set;
    logic       rx_ferr_set;

    assign rx_ie    = ctrl[0];
    assign tx_ie    = ctrl[1];
    assign par_en   = ctrl[2];
    assign par_odd  = ctrl[3];
    assign two_stop = ctrl[4];
    assign loopback = ctrl[5];

    assign acc     = i_cs && !cs_q;
    assign rd_acc  = acc && i_rw;
    assign wr_acc  = acc && !i_rw;
    assign err_clr = rd_acc && (i_addr == 2'd1);

    assign txf_push = wr_acc && (i_addr == 2'd0);
    assign rxf_pop  = rd_acc && (i_addr == 2'd0);
    assign rxf_push = rx_push_req;

    assign rx_head = rxf_empty ? 8'h00 : rxf_dout;
    assign status  = {~o_irq_n, perr, ferr, ovr, rxf_full, txf_full,
                      (!txf_empty || tx_state != TX_IDLE), !rxf_empty};

    assign irq_cond = (rx_ie && (!rxf_empty || perr || ferr || ovr)) ||
                      (tx_ie && txf_empty && tx_state == TX_IDLE);

    // The access strobe clears errors and pops data, so later cycles of the
    // same access replay what was seen at the strobe.
    always_comb begin
        rd_mux = 8'h00;
        case (i_addr)
            2'd0:    rd_mux = acc ? rx_head : rx_hold;
            2'd1:    rd_mux = acc ? status : (status | {1'b0, err_hold, 4'b0000});
            2'd2:    rd_mux = {2'b00, ctrl[5:0]};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q     <= 1'b0;
            o_rdata  <= 8'h00;
            rx_hold  <= 8'h00;
            err_hold <= 3'b000;
            ctrl     <= 8'h00;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
            o_irq_n  <= 1'b1;
        end else begin
            cs_q <= i_cs;
            if (acc) begin
                rx_hold  <= rx_head;
                err_hold <= {perr, ferr, ovr};
            end
            if (i_cs && i_rw) o_rdata <= rd_mux;
            if (wr_acc && i_addr == 2'd2) ctrl <= i_wdata;
            else                          ctrl[7:6] <= 2'b00;
            perr    <= (perr && !err_clr) || rx_perr_set;
            ferr    <= (ferr && !err_clr) || rx_ferr_set;
            ovr     <= (ovr && !err_clr) || (rx_push_req && rxf_full);
            o_irq_n <= !irq_cond;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt <= '0;
        else if (div_cnt == DIV_W'(CLK_DIV - 1)) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
    end
    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    uart_fifo_sync #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (ctrl[6]),
        .push  (txf_push),
        .din   (i_wdata),
        .pop   (txf_pop),
        .dout  (txf_dout),
        .full  (txf_full),
        .empty (txf_empty)
    );

    uart_fifo_sync #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (ctrl[7]),
        .push  (rxf_push),
        .din   (rx_shift),
        .pop   (rxf_pop),
        .dout  (rxf_dout),
        .full  (rxf_full),
        .empty (rxf_empty)
    );

    // ---------------- TX state machine ----------------
    assign tx_bit_end = tick && (tx_scnt == LAST_SAMPLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_scnt_n  = tx_scnt;
        tx_bitn_n  = tx_bitn;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        txf_pop    = 1'b0;
        tx_done    = 1'b0;
        tx_line_n  = 1'b1;

        if (tick) tx_scnt_n = tx_bit_end ? 4'd0 : tx_scnt + 4'd1;

        case (tx_state)
            TX_START:  if (tx_bit_end) begin
                           tx_state_n = TX_DATA;
                           tx_bitn_n  = 3'd0;
                       end
            TX_DATA:   if (tx_bit_end) begin
                           tx_shift_n = {1'b0, tx_shift[7:1]};
                           tx_bitn_n  = tx_bitn + 3'd1;
                           if (tx_bitn == 3'd7) tx_state_n = par_en ? TX_PARITY : TX_STOP1;
                       end
            TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP1;
            TX_STOP1:  if (tx_bit_end) begin
                           if (two_stop) tx_state_n = TX_STOP2;
                           else          tx_done    = 1'b1;
                       end
            TX_STOP2:  if (tx_bit_end) tx_done = 1'b1;
            default:   ;
        endcase

        // Reloading straight out of the last stop bit keeps frames gap-free.
        if ((tx_state == TX_IDLE && tick) || tx_done) begin
            if (!txf_empty) begin
                txf_pop    = 1'b1;
                tx_shift_n = txf_dout;
                tx_par_n   = (^txf_dout) ^ par_odd;
                tx_state_n = TX_START;
                tx_scnt_n  = 4'd0;
            end else begin
                tx_state_n = TX_IDLE;
            end
        end

        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shift_n[0];
            TX_PARITY: tx_line_n = tx_par_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= TX_IDLE;
            tx_scnt   <= 4'd0;
            tx_bitn   <= 3'd0;
            tx_shift  <= 8'h00;
            tx_par    <= 1'b0;
            o_uart_tx <= 1'b1;
        end else begin
            tx_state  <= tx_state_n;
            tx_scnt   <= tx_scnt_n;
            tx_bitn   <= tx_bitn_n;
            tx_shift  <= tx_shift_n;
            tx_par    <= tx_par_n;
            o_uart_tx <= tx_line_n;
        end
    end

    // ---------------- RX state machine ----------------
    assign rx_line    = loopback ? o_uart_tx : rx_sync[1];
    assign rx_bit_end = tick && (rx_scnt == LAST_SAMPLE);

    always_comb begin
        rx_state_n  = rx_state;
        rx_scnt_n   = rx_scnt;
        rx_bitn_n   = rx_bitn;
        rx_shift_n  = rx_shift;
        rx_push_req = 1'b0;
        rx_perr_set = 1'b0;
        rx_ferr_set = 1'b0;

        if (tick) rx_scnt_n = rx_bit_end ? 4'd0 : rx_scnt + 4'd1;

        case (rx_state)
            RX_IDLE:   if (tick && !rx_line) begin
                           rx_state_n = RX_START;
                           rx_scnt_n  = 4'd0;
                       end
            // Mid start bit: a line already back high was only a glitch.
            RX_START:  if (tick && rx_scnt == MID_SAMPLE) begin
                           rx_scnt_n  = 4'd0;
                           rx_bitn_n  = 3'd0;
                           rx_state_n = rx_line ? RX_IDLE : RX_DATA;
                       end
            RX_DATA:   if (rx_bit_end) begin
                           rx_shift_n = {rx_line, rx_shift[7:1]};
                           rx_bitn_n  = rx_bitn + 3'd1;
                           if (rx_bitn == 3'd7) rx_state_n = par_en ? RX_PARITY : RX_STOP;
                       end
            RX_PARITY: if (rx_bit_end) begin
                           rx_perr_set = (rx_line != ((^rx_shift) ^ par_odd));
                           rx_state_n  = RX_STOP;
                       end
            RX_STOP:   if (rx_bit_end) begin
                           rx_push_req = 1'b1;
                           rx_ferr_set = !rx_line;
                           rx_state_n  = RX_IDLE;
                       end
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_scnt  <= 4'd0;
            rx_bitn  <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_sync  <= {rx_sync[0], i_uart_rx};
            rx_state <= rx_state_n;
            rx_scnt  <= rx_scnt_n;
            rx_bitn  <= rx_bitn_n;
            rx_shift <= rx_shift_n;
        end
    end
endmodule

`default_nettype wire
